// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 16-channel mux scan controller.
`timescale 1ns/1ps
package mux_scan_pkg;

  localparam int CH_NUM = 16;
  localparam int SEL_W  = 4;

  // Select value of the final channel; reaching it in SAMPLE publishes the word.
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CH_NUM - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scanState_t;

  // Returns word with the bit at idx replaced by val.
  function automatic logic [CH_NUM-1:0] setBit(
    input logic [CH_NUM-1:0] word,
    input logic [SEL_W-1:0]  idx,
    input logic              val
  );
    logic [CH_NUM-1:0] result;
    result      = word;
    result[idx] = val;
    return result;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Settle counter: counts cycles spent on one channel and flags when the
// latched dwell value has been reached.
`timescale 1ns/1ps
module dwell_counter #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_enable,
  input  logic [DWELL_W-1:0] i_limit,
  output logic               o_terminal
);

  logic [DWELL_W-1:0] r_count;

  // Clear has priority so a fresh channel always starts counting from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + DWELL_W'(1);
    end
  end

  assign o_terminal = (r_count == i_limit);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps a downstream 16:1 mux through every channel, waits a programmable
// settle time on each, samples the mux output and publishes a 16-bit word.
`timescale 1ns/1ps
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_cont,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic               i_mux_y,
  output logic [3:0]         o_sel,
  output logic               o_busy,
  output logic               o_done,
  output logic [15:0]        o_scan_word
);

  scanState_t r_state;
  scanState_t w_nextState;

  logic [DWELL_W-1:0] r_dwellQ;
  logic [SEL_W-1:0]   r_sel;
  logic [CH_NUM-1:0]  r_shadow;
  logic [CH_NUM-1:0]  r_scanWord;
  logic               r_busy;
  logic               r_done;

  logic               w_terminal;
  logic               w_latchScan;
  logic               w_discard;
  logic               w_sampleWrite;
  logic               w_selInc;
  logic               w_publish;
  logic               w_cntClear;
  logic               w_cntEnable;
  logic               w_busyNext;
  logic               w_doneNext;
  logic [CH_NUM-1:0]  w_shadowSampled;

  // The shadow as it will look once the current channel's sample is written,
  // so the last channel lands in the published word on the same edge.
  assign w_shadowSampled = setBit(r_shadow, r_sel, i_mux_y);

  dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwellCounter (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_cntClear),
    .i_enable   (w_cntEnable),
    .i_limit    (r_dwellQ),
    .o_terminal (w_terminal)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; abort beats every other request, including start in IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (i_start && !i_abort) begin
          w_nextState = SETTLE;
        end
      end
      SETTLE: begin
        if (i_abort) begin
          w_nextState = IDLE;
        end else if (w_terminal) begin
          w_nextState = SAMPLE;
        end
      end
      SAMPLE: begin
        if (i_abort) begin
          w_nextState = IDLE;
        end else if (r_sel == SEL_LAST) begin
          w_nextState = DONE;
        end else begin
          w_nextState = SETTLE;
        end
      end
      DONE: begin
        if (i_abort) begin
          w_nextState = IDLE;
        end else if (i_cont) begin
          w_nextState = SETTLE;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath strobes and next values of the registered status outputs.
  always_comb begin
    w_latchScan   = 1'b0;
    w_discard     = 1'b0;
    w_sampleWrite = 1'b0;
    w_selInc      = 1'b0;
    w_publish     = 1'b0;
    case (r_state)
      IDLE: begin
        w_latchScan = i_start && !i_abort;
      end
      SETTLE: begin
        w_discard = i_abort;
      end
      SAMPLE: begin
        if (i_abort) begin
          w_discard = 1'b1;
        end else begin
          w_sampleWrite = 1'b1;
          if (r_sel == SEL_LAST) begin
            w_publish = 1'b1;
          end else begin
            w_selInc = 1'b1;
          end
        end
      end
      DONE: begin
        if (i_abort) begin
          w_discard = 1'b1;
        end else begin
          w_latchScan = i_cont;
        end
      end
      default: begin
        w_discard = 1'b1;
      end
    endcase
    w_cntClear  = (r_state != SETTLE) || (w_nextState != SETTLE);
    w_cntEnable = !w_cntClear;
    w_busyNext  = (w_nextState != IDLE);
    w_doneNext  = (w_nextState == DONE);
  end

  // Scan datapath: dwell latch, channel select, shadow word and published word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwellQ   <= '0;
      r_sel      <= '0;
      r_shadow   <= '0;
      r_scanWord <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy <= w_busyNext;
      r_done <= w_doneNext;
      if (w_latchScan) begin
        r_dwellQ <= i_dwell;
        r_shadow <= '0;
        r_sel    <= '0;
      end else if (w_discard) begin
        r_shadow <= '0;
        r_sel    <= '0;
      end else begin
        if (w_sampleWrite) begin
          r_shadow <= w_shadowSampled;
        end
        if (w_selInc) begin
          r_sel <= r_sel + SEL_W'(1);
        end
        if (w_publish) begin
          r_scanWord <= w_shadowSampled;
        end
      end
    end
  end

  assign o_sel       = r_sel;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_scan_word = r_scanWord;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl with a behavioural 16:1 mux.
`timescale 1ns/1ps
module tb_mux_scan_ctrl;

   typedef struct packed {
      logic [15:0] word;
      int          edgeNum;
   } expScan_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic        cont;
   logic [3:0]  dwell;
   logic        muxY;
   logic [3:0]  sel;
   logic        busy;
   logic        done;
   logic [15:0] scanWord;
   logic [15:0] muxIn;

   int          assertCount = 0;
   int          failCount = 0;
   int          cycleNum = 0;
   expScan_t    expQ[$];
   expScan_t    monItem;

   // Free-running clock and an edge counter used to time-stamp done pulses.
   always #5 clk = ~clk;

   always @(posedge clk) cycleNum++;

   // Behavioural downstream mux.
   assign muxY = muxIn[sel];

   mux_scan_ctrl #(
      .DWELL_W (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .i_abort     (abort),
      .i_cont      (cont),
      .i_dwell     (dwell),
      .i_mux_y     (muxY),
      .o_sel       (sel),
      .o_busy      (busy),
      .o_done      (done),
      .o_scan_word (scanWord)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic a, input logic c, input logic [3:0] d);
      @(negedge clk);
      start = s;
      abort = a;
      cont  = c;
      dwell = d;
   endtask

   task automatic skipCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Wait (bounded) until the monitor has retired every queued scan.
   task automatic waitScoreboard(input int budget);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      checkOutput("pendingScans", expQ.size(), 0);
      expQ.delete();
   endtask

   // Wait (bounded) for a done pulse seen at a negedge.
   task automatic waitForDone(input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput("doneSeen", done, 1);
   endtask

   // Monitor: every done pulse must match the oldest expected scan in word and timing.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpectedDone: got done=1 at edge %0d, required no pending scan", cycleNum);
         end else begin
            monItem = expQ.pop_front();
            checkOutput("scanWord", scanWord, monItem.word);
            checkOutput("doneEdge", cycleNum, monItem.edgeNum);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of test, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence. A start driven at a negedge with cycleNum=c is sampled
   // at edge c+1; done for dwell d is then visible after edge c+1+16*(d+2),
   // i.e. in the 33rd (d=0) or 81st (d=3) cycle after the start edge.
   initial begin
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      cont  = 1'b0;
      dwell = 4'd0;
      muxIn = 16'hA5C3;
      skipCycles(2);
      checkOutput("resetSel", sel, 0);
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetDone", done, 0);
      checkOutput("resetWord", scanWord, 0);
      rst = 1'b0;
      skipCycles(3);
      checkOutput("idleAfterReset", busy, 0);

      $display("[TB] abort at sel=7");
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("abortBusyStart", busy, 1);
      skipCycles(13);
      checkOutput("abortSel6", sel, 6);
      applyStimulus(0, 1, 0, 0);
      checkOutput("abortSel7", sel, 7);
      applyStimulus(0, 0, 0, 0);
      checkOutput("abortBusy", busy, 0);
      checkOutput("abortSel", sel, 0);
      checkOutput("abortDone", done, 0);
      checkOutput("abortWord", scanWord, 16'h0000);
      skipCycles(40);

      $display("[TB] start with abort in IDLE");
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("startAbortBusy", busy, 0);
      skipCycles(2);
      checkOutput("startAbortBusyLater", busy, 0);

      $display("[TB] single scan dwell=0");
      applyStimulus(1, 0, 0, 0);
      expQ.push_back('{word: 16'hA5C3, edgeNum: cycleNum + 33});
      applyStimulus(0, 0, 0, 0);
      checkOutput("scanBusy", busy, 1);
      waitScoreboard(100);
      skipCycles(1);
      checkOutput("postScanBusy", busy, 0);
      checkOutput("postScanDone", done, 0);

      $display("[TB] single scan dwell=3, dwell change and start mid-scan");
      applyStimulus(1, 0, 0, 3);
      expQ.push_back('{word: 16'hA5C3, edgeNum: cycleNum + 81});
      applyStimulus(0, 0, 0, 3);
      checkOutput("dw3SelK0", sel, 0);
      skipCycles(4);
      checkOutput("dw3SelK4", sel, 0);
      skipCycles(1);
      checkOutput("dw3SelK5", sel, 1);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      skipCycles(2);
      checkOutput("dw3SelK9", sel, 1);
      skipCycles(1);
      checkOutput("dw3SelK10", sel, 2);
      waitScoreboard(150);
      skipCycles(1);
      checkOutput("dw3PostBusy", busy, 0);
      skipCycles(40);
      checkOutput("dw3NoRequeue", busy, 0);

      $display("[TB] continuous mode");
      muxIn = 16'hA5C3;
      applyStimulus(1, 0, 1, 0);
      expQ.push_back('{word: 16'hA5C3, edgeNum: cycleNum + 33});
      expQ.push_back('{word: 16'h0F0F, edgeNum: cycleNum + 66});
      applyStimulus(0, 0, 1, 0);
      waitForDone(100);
      muxIn = 16'h0F0F;
      checkOutput("contBusyAtDone", busy, 1);
      skipCycles(1);
      checkOutput("contBusyRestart", busy, 1);
      checkOutput("contDoneOneCycle", done, 0);
      applyStimulus(0, 0, 0, 0);
      waitScoreboard(100);
      skipCycles(1);
      checkOutput("contStopBusy", busy, 0);

      $display("[TB] reset mid-scan at sel=9");
      muxIn = 16'hA5C3;
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      skipCycles(18);
      checkOutput("rstSel9", sel, 9);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rstSel", sel, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstDone", done, 0);
      checkOutput("rstWord", scanWord, 16'h0000);
      @(negedge clk);
      rst = 1'b0;
      skipCycles(3);
      checkOutput("rstIdle", busy, 0);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("rstStartAbortBusy", busy, 0);
      skipCycles(5);
      checkOutput("rstStartAbortWord", scanWord, 16'h0000);

      skipCycles(5);
      checkOutput("finalPending", expQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: DWELL_W, default 4, width of the per-channel settle count.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request one scan; sampled in IDLE only.
REQ-005 Port: abort  input  1  terminate the scan in progress.
REQ-006 Port: cont  input  1  continuous mode; when high, a finished scan restarts automatically.
REQ-007 Port: dwell  input  DWELL_W  settle count; latched at scan start.
REQ-008 Port: mux_y  input  1  output of the downstream 16:1 mux.
REQ-009 Port: sel  output  4  channel select driven to the downstream 16:1 mux.
REQ-010 Port: busy  output  1  high in every state except IDLE.
REQ-011 Port: done  output  1  single-cycle pulse when a complete scan word is published.
REQ-012 Port: scan_word  output  16  last complete scan; bit i = mux_y sampled while sel==i.

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 IDLE with start=1 and abort=0 SHALL do the following on the next edge: latch dwell into dwell_q, clear the shadow word, set sel=0 and cnt=0, and enter SETTLE.
REQ-015 SETTLE SHALL hold sel and increment cnt; when cnt==dwell_q it SHALL enter SAMPLE. SETTLE therefore lasts dwell_q+1 cycles; dwell_q=0 gives 1 cycle.
REQ-016 SAMPLE SHALL write mux_y into shadow[sel].
REQ-017 From SAMPLE with sel<15: increment sel, clear cnt, return to SETTLE.
REQ-018 From SAMPLE with sel==15: load scan_word with the complete shadow (including bit 15) and enter DONE.
REQ-019 Each channel SHALL take exactly dwell_q+2 cycles; DONE is entered 16*(dwell_q+2)+1 cycles after the start edge.
REQ-020 done SHALL be high for exactly the one cycle spent in DONE.
REQ-021 DONE with cont=1: re-latch dwell, clear the shadow, set sel=0, enter SETTLE; busy stays high.
REQ-022 DONE with cont=0: enter IDLE.
REQ-023 sel SHALL wrap only via the REQ-021 restart; sel never exceeds 15 and never increments outside SAMPLE.
REQ-024 abort=1 in SETTLE, SAMPLE or DONE SHALL force IDLE on the next edge with sel=0, done=0 and scan_word unchanged; a partial shadow is discarded.
REQ-025 abort and start high together in IDLE: abort wins; the FSM stays in IDLE.
REQ-026 start while busy SHALL be ignored and not queued.
REQ-027 A change of dwell mid-scan SHALL have no effect until the next latch point.
REQ-028 scan_word SHALL change only in the SAMPLE-to-DONE transition of REQ-018 and on reset.

Reset
REQ-029 rst=1 SHALL immediately force the following, regardless of clk, including mid-scan: state=IDLE, sel=0, cnt=0, dwell_q=0, shadow=0, scan_word=0, busy=0, done=0.
REQ-030 After rst deasserts, the first scan SHALL begin only on a start sampled in IDLE.

Structure
REQ-031 Package mux_scan_pkg SHALL hold the state enumeration and the constants CH_NUM=16 and SEL_W=4.
REQ-032 Sub-module dwell_counter SHALL implement the DWELL_W-bit settle counter, with clear/enable inputs and a terminal-count output (cnt==dwell_q).
REQ-033 All outputs SHALL be registered; no combinational path from mux_y to any output.

Verification
REQ-034 Bench SHALL model the 16:1 mux as y=in[sel] with in=16'hA5C3.
- dwell=0, start pulse -> done at cycle 33 after the start edge, scan_word=16'hA5C3.
REQ-035 dwell=3 -> each sel value held 5 cycles; done at cycle 81; scan_word=16'hA5C3.
REQ-036 dwell=0, abort asserted while sel=7 -> busy=0 and sel=0 on the next cycle; no done; scan_word keeps its prior value (16'h0000 after reset).
REQ-037 cont=1, dwell=0, in switched from 16'hA5C3 to 16'h0F0F between scans -> done every 33 cycles; scan words are 16'hA5C3 then 16'h0F0F.
REQ-038 rst pulsed mid-cycle while sel=9 -> all outputs 0 before the next clk edge; a start pulse while busy or with abort is ignored.
